// File: rtl/piso_serializer_8bit_if.sv
// Byte-in / bit-out bus for the PISO serializer: parallel handshake,
// bit-rate enable and the serial stream with its framing strobes.
interface piso_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             en;
    logic             so;
    logic             so_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    // Source side: offers bytes, paces the bit rate, watches the stream.
    modport master (
        output din, din_valid, en,
        input  din_ready, so, so_valid, frame_start, frame_end, busy
    );

    // Serializer side.
    modport slave (
        input  din, din_valid, en,
        output din_ready, so, so_valid, frame_start, frame_end, busy
    );
endinterface

// File: rtl/piso_serializer_8bit.sv
// Double-buffered parallel-in serial-out transmitter: one-entry holding
// register feeding a shifter, so back-to-back bytes leave with no idle bits.
module piso_serializer_8bit #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic   clk,
    input  logic   reset,
    piso_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] hold_reg, hold_next;
    logic             hold_full_reg, hold_full_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;

    logic last_bit;
    logic load;
    logic din_ready;
    logic xfer;

    // The last bit is only consumed on an enabled cycle; that is also the
    // moment the shifter may be refilled from hold without a gap.
    assign last_bit  = (state_reg == SHIFT) && bus.en && (bit_cnt_reg == LAST_BIT);
    assign load      = hold_full_reg && ((state_reg == IDLE) || last_bit);
    assign din_ready = !reset && (!hold_full_reg || load);
    assign xfer      = bus.din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            shreg_reg     <= '0;
            bit_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            shreg_reg     <= shreg_next;
            bit_cnt_reg   <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        shreg_next     = shreg_reg;
        bit_cnt_next   = bit_cnt_reg;

        // A transfer can only land in hold when it is empty or being drained.
        if (xfer) begin
            hold_next      = bus.din;
            hold_full_next = 1'b1;
        end else if (load) begin
            hold_full_next = 1'b0;
        end

        if (load) begin
            shreg_next   = hold_reg;
            bit_cnt_next = '0;
            state_next   = SHIFT;
        end else if (state_reg == SHIFT && bus.en) begin
            if (bit_cnt_reg == LAST_BIT) begin
                state_next   = IDLE;
                bit_cnt_next = '0;
            end else begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
                if (MSB_FIRST) begin
                    shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
                end else begin
                    shreg_next = {1'b0, shreg_reg[WIDTH-1:1]};
                end
            end
        end
    end

    logic tx_bit;
    assign tx_bit = MSB_FIRST ? shreg_reg[WIDTH-1] : shreg_reg[0];

    assign bus.din_ready   = din_ready;
    assign bus.so_valid    = (state_reg == SHIFT);
    assign bus.so          = (state_reg == SHIFT) ? tx_bit : IDLE_LEVEL;
    assign bus.frame_start = (state_reg == SHIFT) && bus.en && (bit_cnt_reg == '0);
    assign bus.frame_end   = last_bit;
    assign bus.busy        = hold_full_reg || (state_reg == SHIFT);

endmodule

// File: tb/tb_piso_serializer_8bit.sv
// Scoreboard bench for piso_serializer_8bit: MSB-first and LSB-first
// instances, directed bytes with hand-computed serial streams.
module tb_piso_serializer_8bit;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    piso_if #(.WIDTH(W)) bus_a ();
    piso_if #(.WIDTH(W)) bus_b ();

    piso_serializer_8bit #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    piso_serializer_8bit #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    typedef struct packed {
        logic b;
        logic fs;
        logic fe;
    } exp_bit_t;

    int tests = 0;
    int fails = 0;

    exp_bit_t     exp_a[$];
    exp_bit_t     exp_b[$];
    logic [W-1:0] exp_byte_a[$];

    logic [W-1:0] sipo = '0;
    int  vcount   = 0;
    int  run_len  = 0;
    int  last_run = 0;
    int  fe_count = 0;
    logic prev_stall = 1'b0;
    logic prev_so    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // stream[7] is the first bit expected on so.
    task automatic push_exp(input bit to_b, input logic [W-1:0] stream);
        for (int i = 0; i < W; i++) begin
            if (to_b) exp_b.push_back(exp_bit_t'{stream[W-1-i], (i == 0), (i == W-1)});
            else      exp_a.push_back(exp_bit_t'{stream[W-1-i], (i == 0), (i == W-1)});
        end
        if (!to_b) exp_byte_a.push_back(stream);
    endtask

    // Monitor for the MSB-first instance, including a downstream SIPO model.
    always @(negedge clk) begin
        exp_bit_t e;
        if (reset) begin
            prev_stall = 1'b0;
            run_len    = 0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_so", bus_a.so, prev_so);
                check("stall_hold_valid", bus_a.so_valid, 1);
            end
            if (bus_a.so_valid) check("busy_while_valid", bus_a.busy, 1);
            if (bus_a.so_valid && bus_a.en) begin
                if (exp_a.size() == 0) begin
                    tests++; fails++;
                    $display("[TB] FAIL unexpected_bit_a: got so=%0b, expected no frame bit", bus_a.so);
                end else begin
                    e = exp_a.pop_front();
                    check("so_a", bus_a.so, e.b);
                    check("frame_start_a", bus_a.frame_start, e.fs);
                    check("frame_end_a", bus_a.frame_end, e.fe);
                end
                sipo = {sipo[W-2:0], bus_a.so};
                if (bus_a.frame_end) begin
                    fe_count++;
                    if (exp_byte_a.size() == 0) begin
                        tests++; fails++;
                        $display("[TB] FAIL sipo_a: got %0h, expected no frame end", sipo);
                    end else begin
                        check("sipo_a", sipo, exp_byte_a.pop_front());
                    end
                end
            end else if (bus_a.so_valid) begin
                check("stall_no_start", bus_a.frame_start, 0);
                check("stall_no_end", bus_a.frame_end, 0);
            end else begin
                check("idle_level_a", bus_a.so, 0);
            end
            if (bus_a.so_valid) begin
                vcount++;
                run_len++;
            end else begin
                if (run_len > 0) last_run = run_len;
                run_len = 0;
            end
            prev_stall = bus_a.so_valid && !bus_a.en;
            prev_so    = bus_a.so;
        end
    end

    // Monitor for the LSB-first instance.
    always @(negedge clk) begin
        exp_bit_t e;
        if (!reset && bus_b.so_valid && bus_b.en) begin
            if (exp_b.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL unexpected_bit_b: got so=%0b, expected no frame bit", bus_b.so);
            end else begin
                e = exp_b.pop_front();
                check("so_b", bus_b.so, e.b);
                check("frame_start_b", bus_b.frame_start, e.fs);
                check("frame_end_b", bus_b.frame_end, e.fe);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send_a(input logic [W-1:0] d, output int waited);
        bit done = 0;
        waited = 0;
        bus_a.din = d;
        bus_a.din_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus_a.din_ready) done = 1;
            else begin
                waited++;
                if (waited > 200) begin
                    tests++; fails++;
                    $display("[TB] FAIL send_a_timeout: got no din_ready, expected accept of %0h", d);
                    done = 1;
                end
            end
        end
        if (waited <= 200) push_exp(1'b0, d);
        @(posedge clk); #1;
        bus_a.din_valid = 1'b0;
        bus_a.din = '0;
    endtask

    task automatic wait_idle_a(output int n);
        n = 0;
        @(negedge clk);
        while (bus_a.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_a", bus_a.busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2, w3, n, v0, f0;
        bit done;
        bus_a.din = '0; bus_a.din_valid = 1'b0; bus_a.en = 1'b1;
        bus_b.din = '0; bus_b.din_valid = 1'b0; bus_b.en = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_so", bus_a.so, 0);
        check("rst_so_valid", bus_a.so_valid, 0);
        check("rst_frame_start", bus_a.frame_start, 0);
        check("rst_frame_end", bus_a.frame_end, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_din_ready", bus_a.din_ready, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_din_ready", bus_a.din_ready, 1);
        @(posedge clk); #1;

        // Single byte 8'hA5 -> 1,0,1,0,0,1,0,1 with 2-edge latency
        v0 = vcount;
        send_a(8'hA5, w);
        $display("[TB] send A5 waited=%0d", w);
        @(negedge clk);
        check("lat_no_bit_yet", bus_a.so_valid, 0);
        check("lat_busy", bus_a.busy, 1);
        @(negedge clk);
        check("lat_first_bit", bus_a.so_valid, 1);
        check("lat_frame_start", bus_a.frame_start, 1);
        wait_idle_a(n);
        check("single_busy_cycles", n, 7);
        check("single_valid_count", vcount - v0, 8);
        check("single_run", last_run, 8);

        // Back-to-back 3C, C3 -> 16 contiguous bits, busy low right after
        send_a(8'h3C, w);
        send_a(8'hC3, w2);
        $display("[TB] send 3C/C3 waited=%0d/%0d", w, w2);
        wait_idle_a(n);
        check("b2b_busy_cycles", n, 16);
        check("b2b_run", last_run, 16);

        // Backpressure: third byte waits for the last bit of the first frame
        send_a(8'h11, w);
        send_a(8'h22, w2);
        send_a(8'h33, w3);
        $display("[TB] send 11/22/33 waited=%0d/%0d/%0d", w, w2, w3);
        check("bp_wait_second", w2, 0);
        check("bp_wait_third", w3, 7);
        wait_idle_a(n);
        check("bp_run", last_run, 24);

        // Stall: en alternates during 8'hF0
        v0 = vcount; f0 = fe_count;
        fork
            send_a(8'hF0, w);
            begin
                repeat (40) begin
                    @(posedge clk); #1 bus_a.en = ~bus_a.en;
                end
                bus_a.en = 1'b1;
            end
        join
        $display("[TB] send F0 with stalls waited=%0d", w);
        wait_idle_a(n);
        check("stall_valid_count", vcount - v0, 15);
        check("stall_frame_ends", fe_count - f0, 1);

        // Reset at bit 4 of 8'hFF with 8'h81 held
        send_a(8'hFF, w);
        send_a(8'h81, w2);
        $display("[TB] send FF/81 waited=%0d/%0d", w, w2);
        n = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (bus_a.so_valid && bus_a.frame_start) done = 1;
            else if (n > 50) begin
                tests++; fails++;
                $display("[TB] FAIL rst_mid_wait: got no frame_start, expected one");
                done = 1;
            end
        end
        repeat (4) @(negedge clk);
        #1;
        exp_a.delete();
        exp_byte_a.delete();
        sipo = '0;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_so", bus_a.so, 0);
        check("midrst_so_valid", bus_a.so_valid, 0);
        check("midrst_busy", bus_a.busy, 0);
        check("midrst_din_ready", bus_a.din_ready, 0);
        @(posedge clk); #1 reset = 1'b0;
        f0 = fe_count;
        send_a(8'h5A, w);
        $display("[TB] send 5A after reset waited=%0d", w);
        wait_idle_a(n);
        check("post_rst_frames", fe_count - f0, 1);

        // LSB-first instance: 8'h01 -> 1,0,0,0,0,0,0,0
        bus_b.din = 8'h01; bus_b.din_valid = 1'b1;
        @(negedge clk);
        check("lsb_din_ready", bus_b.din_ready, 1);
        push_exp(1'b1, 8'h80);
        @(posedge clk); #1 bus_b.din_valid = 1'b0;
        $display("[TB] send 01 to LSB-first instance");
        n = 0;
        @(negedge clk);
        while (bus_b.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("lsb_idle", bus_b.busy, 0);
        check("lsb_busy_cycles", n, 9);

        repeat (3) @(posedge clk);
        check("drain_a", exp_a.size(), 0);
        check("drain_bytes_a", exp_byte_a.size(), 0);
        check("drain_b", exp_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
